systolic_array: RTL and testbench



---
 rtl/systolic_array.sv | 79 +++++++
 tb/tb_systolic_array.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array.sv
// Weight-stationary ROWS x COLS multiply-accumulate array; data and weights shift south, partial sums shift east.
// Define SIGNED_MAC_EN for two's-complement activations/weights (default build is unsigned).
module systolic_array #(
   parameter int ROWS   = 4,
   parameter int COLS   = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_weight,
   input  logic [COLS*DATA_W-1:0]   in_n,
   input  logic [ROWS*ACC_W-1:0]    in_w,
   output logic [COLS*DATA_W-1:0]   out_s,
   output logic [ROWS*ACC_W-1:0]    out_e
);

   logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] a_q;
   logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  p_q;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         logic [DATA_W-1:0] north;
         logic [DATA_W-1:0] a_reg;
         logic [DATA_W-1:0] w_reg;
         logic [ACC_W-1:0]  west;
         logic [ACC_W-1:0]  p_reg;
         logic [ACC_W-1:0]  prod_ext;

         if (r == 0) begin : g_north_edge
            assign north = in_n[c*DATA_W +: DATA_W];
         end else begin : g_north_pe
            assign north = a_q[r-1][c];
         end

         if (c == 0) begin : g_west_edge
            assign west = in_w[r*ACC_W +: ACC_W];
         end else begin : g_west_pe
            assign west = p_q[r][c-1];
         end

         // Size cast extends by the product's signedness: sign-extend when signed, zero-extend otherwise.
`ifdef SIGNED_MAC_EN
         logic signed [2*DATA_W-1:0] prod;
         assign prod = $signed(north) * $signed(w_reg);
`else
         logic [2*DATA_W-1:0] prod;
         assign prod = north * w_reg;
`endif
         assign prod_ext = ACC_W'(prod);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               a_reg <= '0;
               w_reg <= '0;
               p_reg <= '0;
            end else begin
               a_reg <= north;
               if (load_weight) begin
                  w_reg <= north;
                  p_reg <= west;
               end else begin
                  p_reg <= west + prod_ext;
               end
            end
         end

         assign a_q[r][c] = a_reg;
         assign p_q[r][c] = p_reg;
      end

      assign out_e[r*ACC_W +: ACC_W] = p_q[r][COLS-1];
   end

   for (genvar c = 0; c < COLS; c++) begin : g_south
      assign out_s[c*DATA_W +: DATA_W] = a_q[ROWS-1][c];
   end

endmodule

// File: tb/tb_systolic_array.sv
// Directed self-checking bench for the 4x4 systolic_array: reset, pass-through latency, weight load, MAC, wrap.
module tb_systolic_array;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_weight;
   logic [31:0] in_n;
   logic [95:0] in_w;
   logic [31:0] out_s;
   logic [95:0] out_e;

   int total = 0;
   int bad   = 0;

   systolic_array #(.ROWS(4), .COLS(4), .DATA_W(8), .ACC_W(24)) dut (
      .clk         (clk),
      .rst         (rst),
      .load_weight (load_weight),
      .in_n        (in_n),
      .in_w        (in_w),
      .out_s       (out_s),
      .out_e       (out_e)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] row_e(input int r);
      return out_e[r*24 +: 24];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst         = 1'b0;
      load_weight = 1'b0;
      in_n        = '0;
      in_w        = '0;
      tick();
      rst = 1'b1;
   endtask

   task automatic load_uniform(input logic [7:0] w);
      load_weight = 1'b1;
      in_n        = {4{w}};
      for (int k = 0; k < 4; k++) tick();
   endtask

   task automatic test_reset();
      apply_reset();
      load_weight = 1'b1;
      in_n        = $urandom | 32'h01010101;
      in_w        = {$urandom, $urandom, $urandom};
      for (int k = 0; k < 5; k++) tick();
      #3;
      rst = 1'b0;
      #1;
      total++;
      if (out_s !== 32'h0) begin bad++; $display("FAIL reset_async_s: got %h want 0", out_s); end
      total++;
      if (out_e !== 96'h0) begin bad++; $display("FAIL reset_async_e: got %h want 0", out_e); end
      for (int k = 0; k < 3; k++) begin
         in_n = $urandom;
         in_w = {$urandom, $urandom, $urandom};
         load_weight = $urandom_range(0, 1);
         tick();
         total++;
         if (out_s !== 32'h0 || out_e !== 96'h0) begin
            bad++;
            $display("FAIL reset_hold[%0d]: got s=%h e=%h want 0", k, out_s, out_e);
         end
      end
   endtask

   task automatic test_column_pass();
      apply_reset();
      in_n = 32'h000000AA;
      for (int k = 1; k <= 6; k++) begin
         tick();
         total++;
         if (out_s !== ((k >= 4) ? 32'h000000AA : 32'h0)) begin
            bad++;
            $display("FAIL col_pass edge%0d: got %h want %h", k, out_s, (k >= 4) ? 32'h000000AA : 32'h0);
         end
      end
      total++;
      if (out_e !== 96'h0) begin bad++; $display("FAIL col_pass_e: got %h want 0", out_e); end
   endtask

   task automatic test_psum_pass();
      apply_reset();
      in_w[1*24 +: 24] = 24'h123456;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k >= 3) begin
            total++;
            if (row_e(1) !== ((k >= 4) ? 24'h123456 : 24'h0)) begin
               bad++;
               $display("FAIL psum_pass edge%0d: got %h want %h", k, row_e(1), (k >= 4) ? 24'h123456 : 24'h0);
            end
         end
      end
      total++;
      if (row_e(0) !== 24'h0 || row_e(2) !== 24'h0 || row_e(3) !== 24'h0) begin
         bad++;
         $display("FAIL psum_other_rows: got %h want rows 0/2/3 zero", out_e);
      end
   endtask

   task automatic test_weight_mac();
      apply_reset();
      load_uniform(8'h02);
      load_weight = 1'b0;
      in_n        = 32'h01010101;
      in_w        = '0;
      for (int k = 0; k < 12; k++) tick();
      for (int r = 0; r < 4; r++) begin
         total++;
         if (row_e(r) !== 24'h000008) begin
            bad++;
            $display("FAIL mac_row%0d: got %h want 000008", r, row_e(r));
         end
      end
      total++;
      if (out_s !== 32'h01010101) begin bad++; $display("FAIL mac_out_s: got %h want 01010101", out_s); end
      in_w[0 +: 24] = 24'h000010;
      for (int k = 0; k < 6; k++) tick();
      total++;
      if (row_e(0) !== 24'h000018) begin bad++; $display("FAIL mac_west_row0: got %h want 000018", row_e(0)); end
      total++;
      if (row_e(1) !== 24'h000008) begin bad++; $display("FAIL mac_west_row1: got %h want 000008", row_e(1)); end
   endtask

   task automatic test_weight_order();
      logic [7:0] w;
      apply_reset();
      load_weight = 1'b1;
      for (int k = 0; k < 4; k++) begin
         w    = 8'(4 - k);
         in_n = {4{w}};
         tick();
      end
      load_weight = 1'b0;
      in_n        = 32'h01010101;
      in_w        = '0;
      for (int k = 0; k < 12; k++) tick();
      for (int r = 0; r < 4; r++) begin
         total++;
         if (row_e(r) !== 24'(4 * (r + 1))) begin
            bad++;
            $display("FAIL order_row%0d: got %h want %h", r, row_e(r), 24'(4 * (r + 1)));
         end
      end
   endtask

   task automatic test_wrap();
      logic [23:0] exp0, exp1;
`ifdef SIGNED_MAC_EN
      exp0 = 24'h000003;
      exp1 = 24'h000004;
`else
      exp0 = 24'h03F803;
      exp1 = 24'h03F804;
`endif
      apply_reset();
      load_uniform(8'hFF);
      load_weight = 1'b0;
      in_n        = 32'hFFFFFFFF;
      in_w        = '0;
      in_w[0 +: 24] = 24'hFFFFFF;
      for (int k = 0; k < 12; k++) tick();
      total++;
      if (row_e(0) !== exp0) begin bad++; $display("FAIL wrap_row0: got %h want %h", row_e(0), exp0); end
      total++;
      if (row_e(1) !== exp1) begin bad++; $display("FAIL wrap_row1: got %h want %h", row_e(1), exp1); end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      load_uniform(8'h02);
      load_weight = 1'b0;
      in_n        = 32'h01010101;
      for (int k = 0; k < 6; k++) tick();
      #2;
      rst = 1'b0;
      #1;
      total++;
      if (out_s !== 32'h0 || out_e !== 96'h0) begin
         bad++;
         $display("FAIL midreset_async: got s=%h e=%h want 0", out_s, out_e);
      end
      tick();
      rst = 1'b1;
      for (int k = 0; k < 10; k++) tick();
      total++;
      if (out_e !== 96'h0) begin bad++; $display("FAIL midreset_weights: got %h want 0", out_e); end
      total++;
      if (out_s !== 32'h01010101) begin bad++; $display("FAIL midreset_out_s: got %h want 01010101", out_s); end
   endtask

   initial begin
      rst         = 1'b0;
      load_weight = 1'b0;
      in_n        = '0;
      in_w        = '0;
      test_reset();
      test_column_pass();
      test_psum_pass();
      test_weight_mac();
      test_weight_order();
      test_wrap();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
